// File: rtl/peripheral_mpram_bank_if.sv
// rtl/peripheral_mpram_bank_if.sv - request/response bundle between the AXI4 bridge and the memory bank
// Purpose: groups the bridge-side memory request channel with the bank's read response and status.
// Signals:
//   req_i, we_i, addr_i, be_i, data_i : request channel, driven by the bridge (master)
//   data_o, rvalid_o, err_o           : registered read response, driven by the bank (slave)
//   init_done_o, parity_err_o         : bank status, driven by the bank (slave)
interface peripheral_mpram_bank_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16
);
   logic                    req_i;
   logic                    we_i;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic [DATA_WIDTH/8-1:0] be_i;
   logic [DATA_WIDTH-1:0]   data_i;
   logic [DATA_WIDTH-1:0]   data_o;
   logic                    rvalid_o;
   logic                    err_o;
   logic                    init_done_o;
   logic                    parity_err_o;

   modport master (
      output req_i, we_i, addr_i, be_i, data_i,
      input  data_o, rvalid_o, err_o, init_done_o, parity_err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, be_i, data_i,
      output data_o, rvalid_o, err_o, init_done_o, parity_err_o
   );
endinterface

// File: rtl/peripheral_mpram_bank.sv
// rtl/peripheral_mpram_bank.sv - byte-writable synchronous memory bank with power-on clear
// Purpose: serves the bridge's single request channel (one read or one write per cycle) from a
//          MEM_DEPTH x DATA_WIDTH array. After reset the array is cleared word by word before
//          any request is honoured. Reads return registered data one cycle later.
// Ports:
//   HCLK    : clock, rising edge
//   HRESETn : asynchronous active-low reset
//   bus     : peripheral_mpram_bank_if.slave (request in, read data/valid/error/status out)
// Optional feature: define MPRAM_PARITY_EN to store an even-parity bit per byte and flag
//          mismatches on reads through parity_err_o; otherwise parity_err_o is tied low.
module peripheral_mpram_bank #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   peripheral_mpram_bank_if.slave bus
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    cnt;
   logic [IDX_W-1:0]    cnt_nxt;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Address decode: byte offset dropped, word index next, anything above is out of range.
   logic [IDX_W-1:0]    idx;
   logic                oor;
   assign idx = bus.addr_i[OFF_W +: IDX_W];
   assign oor = |(bus.addr_i >> (OFF_W + IDX_W));

   // Single write port shared by the init clear and bridge writes.
   logic                  wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NB-1:0]         wr_be;
   logic                  rd_en;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      wr_idx    = idx;
      wr_data   = bus.data_i;
      wr_be     = bus.be_i;
      rd_en     = 1'b0;
      unique case (state)
         ST_INIT: begin
            // Requests are ignored here; the write port belongs to the clear sweep.
            wr_en   = 1'b1;
            wr_idx  = cnt;
            wr_data = '0;
            wr_be   = '1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == IDX_W'(MEM_DEPTH - 1)) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            wr_en = bus.req_i & bus.we_i & ~oor;
            rd_en = bus.req_i & ~bus.we_i;
         end
      endcase
   end

   // Array storage has no reset; contents become defined once the clear sweep finishes.
   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   logic [DATA_WIDTH-1:0] rd_word;
   assign rd_word = mem[idx];

   logic [DATA_WIDTH-1:0] data_q;
   logic                  rvalid_q;
   logic                  err_q;
   logic                  parity_err_q;

   // data_o/err_o only move on a read, so they hold between rvalid pulses.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         data_q   <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) begin
            data_q <= oor ? '0 : rd_word;
            err_q  <= oor;
         end
      end
   end

`ifdef MPRAM_PARITY_EN
   logic [NB-1:0] par_mem [MEM_DEPTH];
   logic [NB-1:0] wr_par;
   logic [NB-1:0] rd_par;

   always_comb begin
      wr_par = '0;
      rd_par = '0;
      for (int b = 0; b < NB; b++) begin
         wr_par[b] = ^wr_data[b*8 +: 8];
         rd_par[b] = ^rd_word[b*8 +: 8];
      end
   end

   // Parity bits follow their byte, so the init sweep leaves them all zero.
   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               par_mem[wr_idx][b] <= wr_par[b];
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         parity_err_q <= 1'b0;
      end else if (rd_en) begin
         parity_err_q <= ~oor & (|(rd_par ^ par_mem[idx]));
      end
   end
`else
   assign parity_err_q = 1'b0;
`endif

   assign bus.data_o       = data_q;
   assign bus.rvalid_o     = rvalid_q;
   assign bus.err_o        = err_q;
   assign bus.parity_err_o = parity_err_q;
   assign bus.init_done_o  = (state == ST_IDLE);

endmodule

// File: tb/tb_peripheral_mpram_bank.sv
// tb/tb_peripheral_mpram_bank.sv - self-checking bench for peripheral_mpram_bank
module tb_peripheral_mpram_bank;
   localparam int AW    = 32;
   localparam int DW    = 16;
   localparam int DEPTH = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   peripheral_mpram_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   peripheral_mpram_bank #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MEM_DEPTH (DEPTH)
   ) dut (
      .HCLK   (clk),
      .HRESETn(rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words as plain array, init as a countdown of remaining clear cycles.
   int          init_left = DEPTH;
   logic [15:0] mmem [DEPTH];
   logic        m_rvalid  = 1'b0;
   logic [15:0] m_data    = 16'h0;
   logic        m_err     = 1'b0;
   logic        m_perr    = 1'b0;
   int          flip_idx  = -1;
   logic [7:0]  m_idx;
   logic        m_oor;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_left = DEPTH;
         m_rvalid  = 1'b0;
         m_data    = 16'h0;
         m_err     = 1'b0;
         m_perr    = 1'b0;
         flip_idx  = -1;
         for (int i = 0; i < DEPTH; i++) mmem[i] = 16'h0;
      end else begin
         m_rvalid = 1'b0;
         m_idx    = bus.addr_i[8:1];
         m_oor    = (bus.addr_i[31:9] != 23'h0);
         if (init_left > 0) begin
            init_left--;
         end else if (bus.req_i) begin
            if (bus.we_i) begin
               if (!m_oor) begin
                  for (int b = 0; b < 2; b++)
                     if (bus.be_i[b]) mmem[m_idx][b*8 +: 8] = bus.data_i[b*8 +: 8];
               end
            end else begin
               m_rvalid = 1'b1;
               m_data   = m_oor ? 16'h0 : mmem[m_idx];
               m_err    = m_oor;
               m_perr   = !m_oor && (int'(m_idx) == flip_idx);
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_rvalid", 32'(bus.rvalid_o), 32'(m_rvalid));
      check("cmp_init_done", 32'(bus.init_done_o), 32'(init_left == 0));
      check("cmp_data", 32'(bus.data_o), 32'(m_data));
      if (m_rvalid) begin
         check("cmp_err", 32'(bus.err_o), 32'(m_err));
         check("cmp_parity_err", 32'(bus.parity_err_o), 32'(m_perr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be);
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b1;
      bus.addr_i = a;
      bus.data_i = d;
      bus.be_i   = be;
      tick();
      bus.req_i  = 1'b0;
      bus.we_i   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [15:0] ed, input logic ee, input string nm);
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = a;
      tick();
      bus.req_i  = 1'b0;
      check({nm, "_rvalid"}, 32'(bus.rvalid_o), 32'h1);
      check({nm, "_data"}, 32'(bus.data_o), 32'(ed));
      check({nm, "_err"}, 32'(bus.err_o), 32'(ee));
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (bus.init_done_o !== 1'b1 && n < 1000) begin
         tick();
         n++;
         bus.req_i = 1'b0;
      end
   endtask

   initial begin
      int n;
      bus.req_i  = 1'b0;
      bus.we_i   = 1'b0;
      bus.addr_i = '0;
      bus.be_i   = '0;
      bus.data_i = '0;

      repeat (3) tick();
      check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("rst_data", 32'(bus.data_o), 32'h0);
      check("rst_err", 32'(bus.err_o), 32'h0);
      check("rst_init_done", 32'(bus.init_done_o), 32'h0);
      check("rst_parity_err", 32'(bus.parity_err_o), 32'h0);

      // Release reset with a read of 0x0 pending in the first INIT cycle; it must be dropped.
      rst_n      = 1'b1;
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h0;
      wait_init(n);
      check("init_cycles", 32'(n), 32'd256);

      rd(32'h1FE, 16'h0000, 1'b0, "rd_top_word");

      wr(32'h10, 16'hA5C3, 2'b11);
      wr(32'h10, 16'hFFFF, 2'b01);
      rd(32'h10, 16'hA5FF, 1'b0, "rd_be_merge");

      wr(32'h30, 16'hFFFF, 2'b00);
      rd(32'h30, 16'h0000, 1'b0, "rd_be_none");
      wr(32'h30, 16'h7788, 2'b10);
      rd(32'h30, 16'h7700, 1'b0, "rd_be_hi");

      wr(32'h20, 16'h1234, 2'b11);
      rd(32'h20, 16'h1234, 1'b0, "rd_after_wr");

      // Three reads in consecutive cycles.
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h20;
      tick();
      bus.addr_i = 32'h10;
      check("b2b0_rvalid", 32'(bus.rvalid_o), 32'h1);
      check("b2b0_data", 32'(bus.data_o), 32'h1234);
      tick();
      bus.addr_i = 32'h20;
      check("b2b1_rvalid", 32'(bus.rvalid_o), 32'h1);
      check("b2b1_data", 32'(bus.data_o), 32'hA5FF);
      tick();
      bus.req_i = 1'b0;
      check("b2b2_rvalid", 32'(bus.rvalid_o), 32'h1);
      check("b2b2_data", 32'(bus.data_o), 32'h1234);
      tick();
      check("idle_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("hold_data", 32'(bus.data_o), 32'h1234);

      wr(32'h200, 16'hBEEF, 2'b11);
      rd(32'h200, 16'h0000, 1'b1, "rd_oor");
      rd(32'h0, 16'h0000, 1'b0, "rd_no_alias");

`ifdef MPRAM_PARITY_EN
      wr(32'h40, 16'h1234, 2'b11);
      rd(32'h40, 16'h1234, 1'b0, "rd_par_clean");
      check("par_clean", 32'(bus.parity_err_o), 32'h0);
      dut.par_mem[32][0] = ~dut.par_mem[32][0];
      flip_idx = 32;
      rd(32'h40, 16'h1234, 1'b0, "rd_par_flip");
      check("par_flip", 32'(bus.parity_err_o), 32'h1);
`endif

      // Reset while a read response is on the bus.
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h10;
      tick();
      bus.req_i = 1'b0;
      check("pre_rst_rvalid", 32'(bus.rvalid_o), 32'h1);
      check("pre_rst_data", 32'(bus.data_o), 32'hA5FF);
      rst_n = 1'b0;
      #1;
      check("midop_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("midop_rst_data", 32'(bus.data_o), 32'h0);
      check("midop_rst_init_done", 32'(bus.init_done_o), 32'h0);
      tick();
      rst_n = 1'b1;

      // Reset again in the middle of the clear sweep.
      repeat (100) tick();
      check("midinit_init_done", 32'(bus.init_done_o), 32'h0);
      rst_n = 1'b0;
      #1;
      check("midinit_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("midinit_rst_init_done", 32'(bus.init_done_o), 32'h0);
      tick();
      rst_n = 1'b1;
      wait_init(n);
      check("reinit_cycles", 32'(n), 32'd256);
      rd(32'h10, 16'h0000, 1'b0, "rd_cleared");
      rd(32'h30, 16'h0000, 1'b0, "rd_cleared2");
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/peripheral_mpram_bank.md
Name: peripheral_mpram_bank

Overview:
- Synchronous byte-writable memory bank that consumes the simple memory request interface (req/we/addr/be/data) produced by the AXI4-to-memory bridge, and returns read data to it.
- After reset, an internal init FSM clears the whole array before it accepts any request.
- One read port and one write port share a single request channel, so there is at most one access per cycle.
- Registered read data, 1-cycle latency, with an address-range error flag.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the bridge.
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- MEM_DEPTH, 256, number of words; must be a power of two, at least 2.

Ports:
- HCLK  input  1  clock; all state updates on the rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- req_i  input  1  access request, valid for one cycle.
- we_i  input  1  1 = write, 0 = read; qualified by req_i.
- addr_i  input  ADDR_WIDTH  byte address.
- be_i  input  DATA_WIDTH/8  byte enables, used for writes only.
- data_i  input  DATA_WIDTH  write data.
- data_o  output  DATA_WIDTH  read data; connects to the bridge's data_i.
- rvalid_o  output  1  one-cycle pulse; data_o and err_o are valid in this cycle.
- err_o  output  1  out-of-range access flag, qualified by rvalid_o.
- init_done_o  output  1  high once the array clear has completed.
- parity_err_o  output  1  parity mismatch flag, qualified by rvalid_o; see Optional Feature.

Behaviour:
- Reset values: data_o=0, rvalid_o=0, err_o=0, init_done_o=0, parity_err_o=0. FSM goes to INIT and the clear counter is set to 0.
- Address decode:
  - OFF = log2(DATA_WIDTH/8) low bits, ignored (all accesses are word-aligned).
  - IDX = the next log2(MEM_DEPTH) bits, giving the word index.
  - Any nonzero bit above IDX marks the access out-of-range.
- FSM state INIT:
  - Each cycle, write 0 to the word at counter cnt, then increment cnt.
  - When cnt = MEM_DEPTH-1 is written, go to IDLE.
  - INIT lasts exactly MEM_DEPTH cycles.
  - init_done_o rises on the first IDLE cycle and stays high until reset.
- Requests arriving during INIT are dropped: no array update, no rvalid_o.
- FSM state IDLE, write (req_i & we_i):
  - For each byte b with be_i[b]=1, mem[IDX] byte b takes data_i byte b at the clock edge.
  - Bytes with be_i[b]=0 are unchanged; be_i=0 leaves the word unchanged.
  - No rvalid_o is generated for writes.
- FSM state IDLE, read (req_i & ~we_i):
  - On the next cycle, rvalid_o=1 and data_o=mem[IDX].
  - A read of a word written in the previous cycle returns the new data.
- data_o holds its last read value when rvalid_o=0.
- Back-to-back reads (one per cycle) produce back-to-back rvalid_o pulses.
- Out-of-range access:
  - A write is ignored.
  - A read returns data_o=0 with err_o=1 in its rvalid cycle.
  - err_o=0 for in-range reads.
- HRESETn asserted mid-operation: all outputs take their reset values immediately and any pending rvalid is lost. On release, INIT restarts from cnt=0.
- Array contents are not reset asynchronously; they are defined only after INIT completes.

Optional Feature:
- Macro: MPRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte. It is written with the byte, including during INIT clears (parity of 0 is 0).
  - On a read, parity is recomputed for all bytes. parity_err_o=1 in the rvalid cycle if any byte mismatches.
  - Out-of-range reads report parity_err_o=0.
- Undefined: no parity storage; parity_err_o is tied to 0.

Test Plan:
- Reset release, MEM_DEPTH=256 -> init_done_o=0 for 256 cycles, then 1; a read of addr 0x0 issued during INIT gives no rvalid_o.
- After init, read addr 0x1FE -> next cycle rvalid_o=1, data_o=0x0000, err_o=0.
- Write addr 0x10, data 0xA5C3, be=2'b11, then write 0xFFFF with be=2'b01, then read 0x10 -> data_o=0xA5FF.
- Write addr 0x20, data 0x1234, and read 0x20 in the very next cycle -> data_o=0x1234 with rvalid_o in the following cycle; reads of 0x20, 0x10, 0x20 in consecutive cycles -> three consecutive rvalid pulses carrying 0x1234, 0xA5FF, 0x1234.
- Write 0xBEEF to addr 0x200 (out-of-range), then read 0x200 -> data_o=0, err_o=1; read 0x0 -> 0x0000, confirming no aliasing.
- Drop HRESETn mid-INIT (cnt=100) -> outputs reset; after release, init_done_o rises exactly 256 cycles later. With MPRAM_PARITY_EN, force one stored parity bit flipped -> the next read of that word has parity_err_o=1.
